// File: rtl/pwl_pkg.sv
// Shared sign-magnitude types and constants for the piecewise-linear evaluator.
// Combinational helpers only; no state.
// No flow control here; used by pwl_eval and sm_add.
package pwl_pkg;

    localparam int DATA_W = 16;
    localparam int MAG_W  = 15;
    localparam int PROD_W = 2 * MAG_W;

    localparam logic [MAG_W-1:0] MAG_MAX = 15'h7FFF;

    typedef struct packed {
        logic             sign;
        logic [MAG_W-1:0] mag;
    } sm_t;

    // Fold -0 onto +0 so downstream logic sees one encoding of zero.
    function automatic sm_t sm_norm(input sm_t v);
        sm_t r;
        r = v;
        if (v.mag == '0) begin
            r.sign = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/sm_add.sv
// Sign-magnitude adder with magnitude clamp to MAG_MAX.
// Latency: combinational.
// No flow control; zero results are always returned as +0.
module sm_add
    import pwl_pkg::*;
(
    input  sm_t  a,
    input  sm_t  b,
    output sm_t  sum,
    output logic sat
);

    logic           a_s;
    logic           b_s;
    logic [MAG_W:0] mag_sum;

    // A zero magnitude carries no sign, whatever its sign bit says.
    assign a_s = a.sign & (a.mag != '0);
    assign b_s = b.sign & (b.mag != '0);

    // Same sign: add and clamp; different sign: larger minus smaller, larger's sign.
    always_comb begin
        sum     = '0;
        sat     = 1'b0;
        mag_sum = {1'b0, a.mag} + {1'b0, b.mag};
        if (a_s == b_s) begin
            sum.sign = a_s;
            if (mag_sum > {1'b0, MAG_MAX}) begin
                sum.mag = MAG_MAX;
                sat     = 1'b1;
            end else begin
                sum.mag = mag_sum[MAG_W-1:0];
            end
        end else if (a.mag >= b.mag) begin
            sum.sign = a_s;
            sum.mag  = a.mag - b.mag;
        end else begin
            sum.sign = b_s;
            sum.mag  = b.mag - a.mag;
        end
        if (sum.mag == '0) begin
            sum.sign = 1'b0;
        end
    end

endmodule

// File: rtl/pwl_eval.sv
// Sign-magnitude y = m*x + c with saturation; optional sat counter (PWL_EVAL_SAT_CNT_EN).
// Latency: 3 cycles from accept to out_valid, 1 result per cycle.
// Backpressure: single global advance; whole pipe freezes while out_valid && !out_ready.
module pwl_eval
    import pwl_pkg::*;
#(
    parameter int FRAC_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] m,
    input  logic [DATA_W-1:0] c,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] y,
    output logic              sat,
    output logic [DATA_W-1:0] sat_count
);

    logic              adv;

    logic              s1_vld_q;
    sm_t               s1_x_q;
    sm_t               s1_m_q;
    sm_t               s1_c_q;

    logic              s2_vld_q;
    logic [PROD_W-1:0] s2_prod_q;
    logic              s2_sign_q;
    sm_t               s2_c_q;

    logic              out_vld_q;
    sm_t               y_q;
    logic              sat_q;

    logic [PROD_W-1:0] prod_d;
    logic              sign_d;
    logic [PROD_W-1:0] scaled;
    logic              prod_sat;
    sm_t               prod_sm;
    sm_t               y_d;
    logic              add_sat;
    logic              sat_d;

    // The pipe moves only when the output slot is empty or being drained.
    assign adv      = !out_vld_q || out_ready;
    assign in_ready = adv;

    assign prod_d = PROD_W'(s1_x_q.mag) * PROD_W'(s1_m_q.mag);
    assign sign_d = s1_x_q.sign ^ s1_m_q.sign;

    // Truncating rescale of the product, clamped to the 15-bit magnitude range.
    always_comb begin
        scaled       = s2_prod_q >> FRAC_W;
        prod_sat     = scaled > PROD_W'(MAG_MAX);
        prod_sm      = '0;
        prod_sm.sign = s2_sign_q;
        prod_sm.mag  = prod_sat ? MAG_MAX : scaled[MAG_W-1:0];
    end

    sm_add u_add (
        .a   (prod_sm),
        .b   (s2_c_q),
        .sum (y_d),
        .sat (add_sat)
    );

    assign sat_d = prod_sat || add_sat;

    // All three stages share one enable so ordering is preserved under any stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld_q  <= 1'b0;
            s1_x_q    <= '0;
            s1_m_q    <= '0;
            s1_c_q    <= '0;
            s2_vld_q  <= 1'b0;
            s2_prod_q <= '0;
            s2_sign_q <= 1'b0;
            s2_c_q    <= '0;
            out_vld_q <= 1'b0;
            y_q       <= '0;
            sat_q     <= 1'b0;
        end else if (adv) begin
            s1_vld_q  <= in_valid;
            s1_x_q    <= sm_norm(sm_t'(data));
            s1_m_q    <= sm_norm(sm_t'(m));
            s1_c_q    <= sm_norm(sm_t'(c));
            s2_vld_q  <= s1_vld_q;
            s2_prod_q <= prod_d;
            s2_sign_q <= sign_d;
            s2_c_q    <= s1_c_q;
            out_vld_q <= s2_vld_q;
            y_q       <= y_d;
            sat_q     <= sat_d;
        end
    end

    assign out_valid = out_vld_q;
    assign y         = y_q;
    assign sat       = sat_q;

`ifdef PWL_EVAL_SAT_CNT_EN
    logic [DATA_W-1:0] sat_cnt_q;
    logic [DATA_W-1:0] sat_cnt_d;

    // Count delivered saturated results, sticking at all-ones.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (out_vld_q && out_ready && sat_q && (sat_cnt_q != '1)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    // Saturation counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_count = sat_cnt_q;
`else
    assign sat_count = '0;
`endif

endmodule

// File: tb/tb_pwl_eval.sv
module tb_pwl_eval;

`ifdef PWL_EVAL_SAT_CNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] data = '0;
    logic [15:0] m = '0;
    logic [15:0] c = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] y;
    logic        sat;
    logic [15:0] sat_count;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_dlv = 0;

    logic [16:0] exp_q[$];

    logic        hold_q = 1'b0;
    logic [15:0] hold_y = '0;
    logic        hold_sat = 1'b0;

    pwl_eval #(.FRAC_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data      (data),
        .m         (m),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .sat       (sat),
        .sat_count (sat_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Present one vector until accepted; queue its hand-computed result.
    task automatic send(input logic [15:0] d, input logic [15:0] mm, input logic [15:0] cc,
                        input logic [15:0] ey, input logic es, output int acc);
        data     = d;
        m        = mm;
        c        = cc;
        in_valid = 1'b1;
        acc      = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            chk("accept_timeout", {31'b0, in_ready}, 32'd1);
        end else begin
            exp_q.push_back({es, ey});
            n_acc++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int acc, input string tag);
        int when;
        when = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) begin
                when = cyc;
                break;
            end
        end
        chk(tag, (when < 0) ? 32'd999 : 32'(when - acc), 32'd3);
    endtask

    task automatic drain();
        for (int k = 0; k < 100; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard and hold-stability monitor.
    always @(negedge clk) begin
        logic [16:0] e;
        if (reset) begin
            hold_q = 1'b0;
        end else begin
            if (hold_q) begin
                chk("hold_vld", {31'b0, out_valid}, 32'd1);
                chk("hold_y", {16'b0, y}, {16'b0, hold_y});
                chk("hold_sat", {31'b0, sat}, {31'b0, hold_sat});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", {31'b0, out_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("y", {16'b0, y}, {16'b0, e[15:0]});
                    chk("sat", {31'b0, sat}, {31'b0, e[16]});
                    n_dlv++;
                end
            end
            hold_q   = out_valid && !out_ready;
            hold_y   = y;
            hold_sat = sat;
        end
    end

    initial begin
        int acc;
        int base_acc;
        int base_dlv;
        logic seen;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_y", {16'b0, y}, 32'd0);
        chk("rst_sat", {31'b0, sat}, 32'd0);
        chk("rst_sat_count", {16'b0, sat_count}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // 2.0*1.5 - 0.5 = 2.5, with latency check
        send(16'h0200, 16'h0180, 16'h8080, 16'h0280, 1'b0, acc);
        wait_out(acc, "latency");
        drain();
        // 1.0*0.5 - 0.5 = +0
        send(16'h0100, 16'h0080, 16'h8080, 16'h0000, 1'b0, acc);
        drain();
        chk("sat_count_0", {16'b0, sat_count}, 32'd0);
        // product overflow clamps
        send(16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF, 1'b1, acc);
        drain();
        chk("sat_count_1", {16'b0, sat_count}, 32'(CNT_EN));
        // negative sum overflow clamps with sign kept
        send(16'h8100, 16'h7F00, 16'hFF00, 16'hFFFF, 1'b1, acc);
        drain();
        chk("sat_count_2", {16'b0, sat_count}, 32'(2 * CNT_EN));

        // Assorted sign / zero / truncation / boundary cases, back to back
        send(16'h8000, 16'h0100, 16'h0005, 16'h0005, 1'b0, acc); // -0 * 1 + 5
        send(16'h8300, 16'h8200, 16'h8100, 16'h0500, 1'b0, acc); // -3*-2 - 1
        send(16'h0001, 16'h00FF, 16'h8000, 16'h0000, 1'b0, acc); // truncates to 0, c=-0
        send(16'h8001, 16'h0001, 16'h0003, 16'h0003, 1'b0, acc); // -0 product + 3
        send(16'h0100, 16'h8100, 16'h0300, 16'h0200, 1'b0, acc); // -1 + 3
        send(16'h0100, 16'h8200, 16'h8100, 16'h8300, 1'b0, acc); // -2 - 1
        send(16'h7FFF, 16'h0100, 16'h0000, 16'h7FFF, 1'b0, acc); // exactly max, no sat
        send(16'h7FFF, 16'h0100, 16'h0001, 16'h7FFF, 1'b1, acc); // max + 1 clamps
        drain();
        chk("sat_count_3", {16'b0, sat_count}, 32'(3 * CNT_EN));

        // Burst of 8 with out_ready low in relative cycles 2..7
        base_acc = n_acc;
        base_dlv = n_dlv;
        fork
            begin
                int a;
                for (int i = 0; i < 8; i++) begin
                    send(16'((i + 1) << 8), 16'h0100, 16'(i), 16'(((i + 1) << 8) + i), 1'b0, a);
                end
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                @(posedge clk);
                @(negedge clk);
                chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
                chk("accepts_before_stall", 32'(n_acc - base_acc), 32'd3);
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("burst_delivered", 32'(n_dlv - base_dlv), 32'd8);

        // Reset with three transfers in flight
        send(16'h0100, 16'h0100, 16'h0001, 16'h0101, 1'b0, acc);
        send(16'h0100, 16'h0100, 16'h0002, 16'h0102, 1'b0, acc);
        send(16'h0100, 16'h0100, 16'h0003, 16'h0103, 1'b0, acc);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_y", {16'b0, y}, 32'd0);
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("mid_rst_sat_count", {16'b0, sat_count}, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        chk("no_stale", {31'b0, seen}, 32'd0);
        @(posedge clk);
        #1;
        send(16'h0200, 16'h0180, 16'h8080, 16'h0280, 1'b0, acc);
        wait_out(acc, "post_rst_latency");
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pwl_eval.md
PWL_EVAL -- requirements
Module: pwl_eval

Interface
REQ-001 SHALL have parameter: FRAC_W, 8, fractional bits of the 15-bit magnitude in data, m, c and y.
REQ-002 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  data/m/c valid this cycle.
REQ-005 SHALL have port: in_ready  output  1  block accepts input this cycle.
REQ-006 SHALL have port: data  input  16  sign-magnitude abscissa x; bit 15 is the sign.
REQ-007 SHALL have port: m  input  16  sign-magnitude segment slope.
REQ-008 SHALL have port: c  input  16  sign-magnitude segment intercept.
REQ-009 SHALL have port: out_valid  output  1  y valid.
REQ-010 SHALL have port: out_ready  input  1  downstream accepts y.
REQ-011 SHALL have port: y  output  16  sign-magnitude result m*x+c.
REQ-012 SHALL have port: sat  output  1  y was clamped; aligned with y.
REQ-013 SHALL have port: sat_count  output  16  saturation event count.

Function
REQ-014 SHALL accept a transfer when in_valid and in_ready are both 1, and deliver one when out_valid and out_ready are both 1.
REQ-015 SHALL use a 3-stage pipeline: S1 registers inputs; S2 forms a 30-bit magnitude product and an XOR sign; S3 scales, adds c, saturates and registers y.
REQ-016 SHALL use a global advance: adv = !out_valid | out_ready; in_ready = adv; all stage registers and valids update only when adv=1.
REQ-017 SHALL present out_valid exactly 3 cycles after acceptance when no stall occurs, with throughput of 1 result per cycle.
REQ-018 SHALL keep y, sat and out_valid stable while out_valid=1 and out_ready=0.
REQ-019 SHALL form the scaled product magnitude as product >> FRAC_W, truncated toward zero; if it exceeds 0x7FFF it SHALL clamp to 0x7FFF and set sat.
REQ-020 SHALL add in sign-magnitude: on equal signs, add magnitudes and keep the sign; on differing signs, subtract the smaller magnitude from the larger and take the larger operand's sign.
REQ-021 SHALL clamp a sum magnitude above 0x7FFF to 0x7FFF, keep the sign, and set sat.
REQ-022 SHALL output a zero result as 0x0000, never 0x8000; an input of -0 SHALL be treated as 0.
REQ-023 SHALL preserve input order with no loss or duplication under any out_ready pattern.
REQ-024 SHALL accept a new input in the same cycle that the output is consumed while the pipeline is full.

Reset
REQ-025 SHALL, while reset=1, clear all stage valids, out_valid, y, sat and sat_count to 0; in_ready SHALL read 1 in the first cycle after reset deasserts.
REQ-026 SHALL discard in-flight data when reset asserts mid-operation and SHALL emit no stale results afterwards.

Configuration
REQ-027 SHALL, with PWL_EVAL_SAT_CNT_EN defined, increment sat_count by 1 on every delivered transfer with sat=1, saturating at 0xFFFF.
REQ-028 SHALL, without PWL_EVAL_SAT_CNT_EN, keep the sat_count port but tie it to 0 and include no counter logic; sat itself is unaffected.

Structure
REQ-029 SHALL place DATA_W=16, MAG_W=15, the sign-magnitude struct typedef (sign, mag) and the 0x7FFF MAG_MAX constant in shared package pwl_pkg, reused by the segment selector.
REQ-030 SHALL implement the add and saturate step as sub-module sm_add, combinational, with 16-bit operands a and b, output sum and flag sat.

Verification (FRAC_W=8)
REQ-031 SHALL cover: data=0x0200, m=0x0180, c=0x8080 -> y=0x0280, sat=0, out_valid 3 cycles after acceptance.
REQ-032 SHALL cover: data=0x0100, m=0x0080, c=0x8080 -> y=0x0000 (not 0x8000), sat=0.
REQ-033 SHALL cover: data=0x7FFF, m=0x7FFF, c=0x0000 -> y=0x7FFF, sat=1, sat_count 0->1 (0 without macro); data=0x8100, m=0x7F00, c=0xFF00 -> y=0xFFFF, sat=1.
REQ-034 SHALL cover: 8 back-to-back inputs with out_ready held 0 for cycles 2-7 -> in_ready falls after 3 accepts, y held stable, all 8 results delivered in order.
REQ-035 SHALL cover: reset pulsed for 1 cycle with 3 transfers in flight -> out_valid=0 next cycle, no stale y ever delivered, a fresh input yields a correct result 3 cycles later.
